multi_ppm_gen: RTL and testbench

- Parametrised multi-channel successor to the single-channel code-to-PPM pulse generator.
- One shared frame counter with a runtime-programmable period drives N_CH independent pulse outputs.
- Per-channel double-buffered codes; host writes are addressed by channel and applied glitch-free at the frame boundary.
- Sits between the flight-control output mixer and the ESC/servo pins.

---
 rtl/ppm_pkg.sv | 10 +
 rtl/ppm_channel.sv | 33 +++
 rtl/multi_ppm_gen.sv | 62 ++++++
 tb/tb_multi_ppm_gen.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ppm_pkg.sv
// ppm_pkg: shared widths, typedefs and helpers for the multi-channel PPM generator.
package ppm_pkg;
   localparam int DEF_CNT_W = 16;
   typedef logic [DEF_CNT_W-1:0] cnt_t;
   typedef logic [3:0] ch_idx_t;
   localparam cnt_t FRAME_MAX = '1;
   function automatic int ch_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/ppm_channel.sv
// ppm_channel: one output channel with double-buffered code, boundary apply and registered compare.
module ppm_channel
   import ppm_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             bnd,
   input  logic             wr,
   input  logic [CNT_W-1:0] code,
   input  logic [CNT_W-1:0] cnt_nxt,
   input  logic             en,
   output logic             ppm,
   output logic             pending
);
   logic [CNT_W-1:0] shadow, active, active_nxt;
   // a write landing on the boundary goes straight to active, skipping the shadow
   assign active_nxt = bnd ? (wr ? code : pending ? shadow : active) : active;
   always_ff @(posedge CLK) begin
      if (RST) begin
         shadow  <= '0;
         active  <= '0;
         pending <= 1'b0;
         ppm     <= 1'b0;
      end else begin
         active  <= active_nxt;
         pending <= bnd ? 1'b0 : (wr | pending);
         if (wr && !bnd) shadow <= code;
         ppm <= en && active_nxt != '0 && cnt_nxt < active_nxt;
      end
   end
endmodule

// File: rtl/multi_ppm_gen.sv
// multi_ppm_gen: shared frame counter driving N_CH PPM outputs.
// Define PPM_CENTER_ALIGN_EN for an up-down counter with centre-aligned pulses.
module multi_ppm_gen
   import ppm_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int CNT_W = DEF_CNT_W,
   parameter int CH_W  = ch_w(N_CH)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [CNT_W-1:0] PERIOD,
   input  logic [CNT_W-1:0] CODE,
   input  logic [CH_W-1:0]  CH,
   input  logic             VALID,
   output logic [N_CH-1:0]  PPM,
   output logic             FRAME,
   output logic [N_CH-1:0]  PENDING
);
   logic [CNT_W-1:0] cnt, cnt_nxt, period_act, period_nxt;
   logic             bnd, en;
   logic [N_CH-1:0]  wr;
   assign period_nxt = bnd ? PERIOD : period_act;
`ifdef PPM_CENTER_ALIGN_EN
   logic up;
   // the turning point only counts as a boundary on the up-count
   assign bnd     = up && cnt == period_act;
   assign cnt_nxt = (up && !bnd) ? cnt + 1'b1 : (cnt == '0 ? '0 : cnt - 1'b1);
   assign en      = period_nxt != '0;
   always_ff @(posedge CLK)
      up <= RST | (cnt_nxt == '0) | (up & !bnd);
`else
   assign bnd     = cnt == period_act;
   assign cnt_nxt = bnd ? '0 : cnt + 1'b1;
   assign en      = 1'b1;
`endif
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt        <= '0;
         period_act <= '0;
         FRAME      <= 1'b0;
      end else begin
         cnt        <= cnt_nxt;
         period_act <= period_nxt;
         FRAME      <= bnd;
      end
   end
   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      assign wr[k] = VALID && CH == CH_W'(k);
      ppm_channel #(.CNT_W(CNT_W)) u_ch (
         .CLK     (CLK),
         .RST     (RST),
         .bnd     (bnd),
         .wr      (wr[k]),
         .code    (CODE),
         .cnt_nxt (cnt_nxt),
         .en      (en),
         .ppm     (PPM[k]),
         .pending (PENDING[k])
      );
   end
endmodule

// File: tb/tb_multi_ppm_gen.sv
// tb_multi_ppm_gen: randomized and directed checks of multi_ppm_gen (edge-aligned build) against a frame-position model.
module tb_multi_ppm_gen;
   localparam int N = 5;
   logic          CLK = 1'b0, RST = 1'b1, VALID = 1'b0;
   logic [15:0]   PERIOD = '0, CODE = '0;
   logic [2:0]    CH = '0;
   logic [N-1:0]  PPM, PENDING;
   logic          FRAME;
   int passes = 0, checks = 0;
   int m_pos, m_per, m_frame;
   int m_sh[N], m_act[N], m_pend[N];

   multi_ppm_gen #(.N_CH(N), .CNT_W(16), .CH_W(3)) dut (
      .CLK(CLK), .RST(RST), .PERIOD(PERIOD), .CODE(CODE), .CH(CH),
      .VALID(VALID), .PPM(PPM), .FRAME(FRAME), .PENDING(PENDING)
   );

   always #5 CLK = ~CLK;

   // model: position within the frame, frame ends when position reaches the loaded period
   task automatic model_step();
      bit b = (m_pos == m_per);
      if (RST) begin
         m_pos = 0; m_per = 0; m_frame = 0;
         for (int k = 0; k < N; k++) begin m_sh[k] = 0; m_act[k] = 0; m_pend[k] = 0; end
         return;
      end
      m_frame = b;
      if (b) begin
         for (int k = 0; k < N; k++) if (m_pend[k] != 0) begin m_act[k] = m_sh[k]; m_pend[k] = 0; end
         if (VALID && CH < N) begin m_act[CH] = CODE; m_pend[CH] = 0; end
         m_pos = 0;
         m_per = PERIOD;
      end else begin
         if (VALID && CH < N) begin m_sh[CH] = CODE; m_pend[CH] = 1; end
         m_pos++;
      end
   endtask

   function automatic logic [N-1:0] exp_ppm();
      for (int k = 0; k < N; k++) exp_ppm[k] = m_act[k] != 0 && m_pos < m_act[k];
   endfunction

   function automatic logic [N-1:0] exp_pend();
      for (int k = 0; k < N; k++) exp_pend[k] = m_pend[k] != 0;
   endfunction

   task automatic step();
      @(posedge CLK);
      model_step();
      #1;
   endtask

   task automatic write(input int ch, input int code);
      VALID = 1'b1; CH = 3'(ch); CODE = 16'(code);
      step();
      VALID = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1; VALID = 1'b1; CH = 3'd0; CODE = 16'd5;
      step(); step();
      checks++; if (PPM !== '0) $display("FAIL reset_ppm got %h want 0", PPM); else passes++;
      checks++; if (FRAME !== 1'b0) $display("FAIL reset_frame got %b want 0", FRAME); else passes++;
      checks++; if (PENDING !== '0) $display("FAIL reset_pending got %h want 0", PENDING); else passes++;
      RST = 1'b0; VALID = 1'b0;
      step();
      checks++; if (FRAME !== 1'b1) $display("FAIL reset_every_cycle_boundary got %b want 1", FRAME); else passes++;
   endtask

   task automatic test_basic();
      int n, h;
      PERIOD = 16'd99;
      step();
      write(0, 25);
      checks++; if (PENDING !== 5'b00001) $display("FAIL basic_pending got %h want 01", PENDING); else passes++;
      for (int i = 0; i < 250; i++) begin
         step();
         checks++;
         if (PPM !== exp_ppm() || FRAME !== m_frame[0] || PENDING !== exp_pend())
            $display("FAIL basic_cycle ppm %h/%h frame %b/%b pend %h/%h", PPM, exp_ppm(), FRAME, m_frame[0], PENDING, exp_pend());
         else passes++;
      end
      for (int i = 0; i < 200 && !FRAME; i++) step();
      n = 0; h = 0;
      do begin h += PPM[0]; n++; step(); end while (!FRAME && n < 1000);
      checks++; if (n != 100) $display("FAIL basic_frame_len got %0d want 100", n); else passes++;
      checks++; if (h != 25) $display("FAIL basic_pulse_width got %0d want 25", h); else passes++;
   endtask

   task automatic test_mid_write();
      int h;
      for (int i = 0; i < 37; i++) step();
      write(1, 40);
      checks++; if (PENDING[1] !== 1'b1) $display("FAIL mid_pending got %b want 1", PENDING[1]); else passes++;
      h = 0;
      while (!FRAME && h < 200) begin
         checks++;
         if (PPM[1] !== 1'b0 || PENDING[1] !== 1'b1) $display("FAIL mid_hold ppm1 %b want 0 pend1 %b want 1", PPM[1], PENDING[1]);
         else passes++;
         step(); h++;
      end
      h = 0;
      for (int i = 0; i < 100; i++) begin h += PPM[1]; step(); end
      checks++; if (h != 40) $display("FAIL mid_pulse_width got %0d want 40", h); else passes++;
      checks++; if (PENDING[1] !== 1'b0) $display("FAIL mid_pending_clear got %b want 0", PENDING[1]); else passes++;
   endtask

   task automatic test_boundary_write();
      int h;
      for (int i = 0; i < 200 && m_pos != m_per; i++) step();
      write(2, 10);
      checks++; if (FRAME !== 1'b1) $display("FAIL bwrite_frame got %b want 1", FRAME); else passes++;
      checks++; if (PENDING[2] !== 1'b0) $display("FAIL bwrite_pending got %b want 0", PENDING[2]); else passes++;
      h = 0;
      for (int i = 0; i < 100; i++) begin h += PPM[2]; step(); end
      checks++; if (h != 10) $display("FAIL bwrite_pulse_width got %0d want 10", h); else passes++;
   endtask

   task automatic test_saturate();
      int bad;
      write(3, 150);
      write(0, 0);
      for (int i = 0; i < 250; i++) begin
         step();
         checks++;
         if (PPM !== exp_ppm() || FRAME !== m_frame[0] || PENDING !== exp_pend())
            $display("FAIL sat_cycle ppm %h/%h frame %b/%b pend %h/%h", PPM, exp_ppm(), FRAME, m_frame[0], PENDING, exp_pend());
         else passes++;
      end
      bad = 0;
      for (int i = 0; i < 220; i++) begin bad += (PPM[3] !== 1'b1) + (PPM[0] !== 1'b0); step(); end
      checks++; if (bad != 0) $display("FAIL sat_glitches got %0d want 0", bad); else passes++;
   endtask

   task automatic test_period_change();
      int n;
      for (int i = 0; i < 200 && !FRAME; i++) step();
      n = 0;
      do begin if (n == 30) PERIOD = 16'd49; n++; step(); end while (!FRAME && n < 1000);
      checks++; if (n != 100) $display("FAIL period_old_frame got %0d want 100", n); else passes++;
      n = 0;
      do begin n++; step(); end while (!FRAME && n < 1000);
      checks++; if (n != 50) $display("FAIL period_new_frame got %0d want 50", n); else passes++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         VALID = ($urandom_range(0, 9) < 3);
         CH    = 3'($urandom_range(0, 7));
         CODE  = 16'($urandom_range(0, 45));
         if ($urandom_range(0, 199) == 0) PERIOD = 16'($urandom_range(0, 40));
         step();
         checks++;
         if (PPM !== exp_ppm() || FRAME !== m_frame[0] || PENDING !== exp_pend())
            $display("FAIL random_cycle ppm %h/%h frame %b/%b pend %h/%h", PPM, exp_ppm(), FRAME, m_frame[0], PENDING, exp_pend());
         else passes++;
      end
      VALID = 1'b0;
   endtask

   task automatic test_reset_mid_pulse();
      int i;
      PERIOD = 16'd20;
      for (i = 0; i < 50 && !FRAME; i++) step();
      write(1, 15);
      for (i = 0; i < 100 && PPM[1] !== 1'b1; i++) step();
      checks++; if (PPM[1] !== 1'b1) $display("FAIL rst_mid_setup ppm1 got %b want 1", PPM[1]); else passes++;
      step();
      RST = 1'b1;
      step();
      RST = 1'b0;
      checks++; if (PPM !== '0 || PENDING !== '0 || FRAME !== 1'b0)
         $display("FAIL rst_mid_clear ppm %h pend %h frame %b want 0", PPM, PENDING, FRAME);
      else passes++;
      for (int j = 0; j < 30; j++) begin
         step();
         checks++;
         if (PPM !== exp_ppm() || FRAME !== m_frame[0] || PENDING !== exp_pend() || PPM !== '0)
            $display("FAIL rst_mid_cycle ppm %h/%h frame %b/%b pend %h/%h", PPM, exp_ppm(), FRAME, m_frame[0], PENDING, exp_pend());
         else passes++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_mid_write();
      test_boundary_write();
      test_saturate();
      test_period_change();
      test_random();
      test_reset_mid_pulse();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
